integer_unit: RTL and testbench
===============================

// Module: integer_unit
// PURPOSE
//  - RV32 integer execute block: operand select, bitwise/add-sub/shift/compare ALU, branch-flag generation.
//  - Sits between the main decoder and regfile writeback.
//  - The combinational flag feeds the program counter's branch decision in the same cycle.
//  - The result is also registered for one-cycle-latency writeback.
// PARAMETERS
//  - XLEN   32   datapath width; must be 32 (shamt is 5 bits)
// PORTS
//  - clk          in   1     single clock; all state updates on posedge
//  - rst          in   1     asynchronous, active-low reset
//  - in_valid     in   1     operands/op on this cycle are valid
//  - alu_imm      in   1     1: operand B = imm; 0: operand B = rs2
//  - rs1          in   32    register operand A
//  - rs2          in   32    register operand B
//  - imm          in   32    decoded, sign-extended ALU immediate
//  - alu_op       in   4     [3:2] category, [1:0] sub-op (encodings below)
//  - flag_inv     in   1     invert compare flag (BNE/BGE/BGEU)
//  - rd_comb      out  32    combinational result
//  - flag         out  1     combinational compare flag, for the branch decision
//  - rd_q         out  32    registered result
//  - flag_q       out  1     registered flag
//  - valid_q      out  1     registered in_valid
// BEHAVIOUR
//  - Operand selection: B = alu_imm ? imm : rs2; A = rs1.
//  - Categories, from alu_op[3:2]:
//    - 00 ALUBT: sub-op 00 NOP -> 0; 01 XOR; 10 OR; 11 AND.
//    - 01 ALUAS: sub-op 01 -> A+B; 00, 10, 11 -> A-B. Both mod 2^32; carry/overflow discarded.
//    - 10 ALUSH:
//      - Shift amount = B[4:0]; upper bits of B are ignored.
//      - 00 SLL, 10 SRL (zero-fill), 11 SRA (sign-fill).
//      - 01 is undefined and yields 0.
//    - 11 ALUFL: rd = {31'b0, flag}. Used for SLT/SLTU/SLTI/SLTIU, and SEQ when flag_inv=0.
//  - Flag: computed from sub-op alu_op[1:0] in every category, then XORed with flag_inv.
//    - 00 AFSUBS: $signed(A) < $signed(B)
//    - 01 AFADD: 0
//    - 10 AFSUBU: A < B, unsigned
//    - 11 AFEQU: A == B
//  - Branch mapping:
//    - BEQ = 11/inv0; BNE = 11/inv1
//    - BLT = 00/inv0; BGE = 00/inv1
//    - BLTU = 10/inv0; BGEU = 10/inv1
//  - rd_comb and flag are purely combinational, with no dependence on clk, rst or in_valid.
//  - Registered path, latency 1 cycle:
//    - On posedge: valid_q <= in_valid.
//    - If in_valid, rd_q <= rd_comb and flag_q <= flag; otherwise rd_q and flag_q hold.
//  - Reset (rst low, async): rd_q = 0, flag_q = 0, valid_q = 0 immediately. They stay 0 while rst is low.
//  - Reset released: the first capture happens on the next posedge with in_valid=1.
//  - Reset mid-operation: in-flight result is discarded; the combinational outputs are unaffected.
//  - Boundaries:
//    - Shift by 0 returns A unchanged.
//    - SRA of 0x80000000 by 31 gives 0xFFFFFFFF.
//    - 0x7FFFFFFF+1 wraps to 0x80000000.
//    - Signed compare of 0x80000000 against 0x00000000 is less-than; unsigned compare is not.
//  - No X propagation: every op/sub-op combination drives a defined value.
// STRUCTURE
//  - Shared package alu_pkg:
//    - Category localparams ALUBT/ALUAS/ALUSH/ALUFL
//    - BTNOP/BTXOR/BTOR/BTAND
//    - AFSUBS/AFADD/AFSUBU/AFEQU
//    - SHSLL/SHSRL/SHSRA
//    - PC-mode and LSU-width codes, shared with the decoder.
//  - One natural sub-module, shift_unit (word, shamt, sign_extend = sub-op[0], shift_right = sub-op[1]).
//  - Compare, add/sub and bitwise logic stay inline.
// TESTING
//  - ADD/SUB: A=0x7FFFFFFF, imm=1, alu_imm=1, op=0101 -> rd_comb=0x80000000. Op 0100 with rs2=1 -> 0x7FFFFFFE.
//  - Bitwise:
//    - A=0xF0F0F0F0, B=0x0FF00FF0.
//    - XOR -> 0xFF00FF00; OR -> 0xFFF0FFF0; AND -> 0x00F000F0.
//    - NOP -> 0x00000000.
//  - Shifts:
//    - A=0x80000001, B=0x21 (shamt 1).
//    - SLL -> 0x00000002; SRL -> 0x40000000; SRA -> 0xC0000000.
//    - Sub-op 01 -> 0.
//  - Compare:
//    - A=0xFFFFFFFF, B=1.
//    - op=1100 -> rd=1, flag=1.
//    - op=1110 -> rd=0.
//    - flag_inv=1 on op=1100 -> flag=0.
//    - A=B=5, op=1111 -> flag=1.
//  - Branch flags: A=3, B=3, op=0011 with flag_inv=0 -> flag 1; with flag_inv=1 -> flag 0 (BEQ taken / BNE not taken).
//  - Registered path and reset:
//    - in_valid=1 ADD 2+3 -> after one posedge rd_q=5, valid_q=1.
//    - in_valid=0 -> rd_q holds 5, valid_q=0.
//    - Assert rst low between edges -> rd_q, flag_q, valid_q read 0 before the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the integer execute path and the main decoder.
package alu_pkg;

    // ALU category, alu_op[3:2]
    localparam logic [1:0] ALUBT = 2'b00;
    localparam logic [1:0] ALUAS = 2'b01;
    localparam logic [1:0] ALUSH = 2'b10;
    localparam logic [1:0] ALUFL = 2'b11;

    // Bitwise sub-ops
    localparam logic [1:0] BTNOP = 2'b00;
    localparam logic [1:0] BTXOR = 2'b01;
    localparam logic [1:0] BTOR  = 2'b10;
    localparam logic [1:0] BTAND = 2'b11;

    // Flag sub-ops, decoded in every category
    localparam logic [1:0] AFSUBS = 2'b00;
    localparam logic [1:0] AFADD  = 2'b01;
    localparam logic [1:0] AFSUBU = 2'b10;
    localparam logic [1:0] AFEQU  = 2'b11;

    // Shift sub-ops: bit 1 = shift right, bit 0 = sign fill
    localparam logic [1:0] SHSLL = 2'b00;
    localparam logic [1:0] SHSRL = 2'b10;
    localparam logic [1:0] SHSRA = 2'b11;

    // Next-PC selection, consumed by the decoder / PC logic
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;
    localparam logic [1:0] PC_JALR   = 2'b11;

    // Load/store access width, consumed by the LSU
    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;

endpackage

// File: rtl/shift_unit.sv
// Barrel shifter for SLL/SRL/SRA. The left shift with sign fill requested
// (sub-op 01) has no meaning and returns zero.
module shift_unit (
    input  logic [31:0] word,
    input  logic [4:0]  shamt,
    input  logic        sign_extend,
    input  logic        shift_right,
    output logic [31:0] result
);

    // Select shift direction and fill
    always_comb begin
        result = '0;
        if (shift_right) begin
            if (sign_extend) begin
                result = $unsigned($signed(word) >>> shamt);
            end else begin
                result = word >> shamt;
            end
        end else if (!sign_extend) begin
            result = word << shamt;
        end
    end

endmodule

// File: rtl/integer_unit.sv
// RV32 integer execute block: operand select, ALU, branch flag, and a
// one-cycle registered copy of result/flag for writeback.
module integer_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            alu_imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic [3:0]      alu_op,
    input  logic            flag_inv,
    output logic [XLEN-1:0] rd_comb,
    output logic            flag,
    output logic [XLEN-1:0] rd_q,
    output logic            flag_q,
    output logic            valid_q
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [1:0]      cat;
    logic [1:0]      sub;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] shift_res;
    logic            raw_flag;

    assign op_a = rs1;
    assign op_b = alu_imm ? imm : rs2;
    assign cat  = alu_op[3:2];
    assign sub  = alu_op[1:0];
    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    shift_unit u_shift (
        .word        (op_a),
        .shamt       (op_b[4:0]),
        .sign_extend (sub[0]),
        .shift_right (sub[1]),
        .result      (shift_res)
    );

    // Compare flag from the sub-op, regardless of category
    always_comb begin
        raw_flag = 1'b0;
        case (sub)
            AFSUBS:  raw_flag = $signed(op_a) < $signed(op_b);
            AFADD:   raw_flag = 1'b0;
            AFSUBU:  raw_flag = op_a < op_b;
            default: raw_flag = op_a == op_b;
        endcase
    end

    assign flag = raw_flag ^ flag_inv;

    // Result mux by category
    always_comb begin
        rd_comb = '0;
        case (cat)
            ALUBT: begin
                case (sub)
                    BTXOR:   rd_comb = op_a ^ op_b;
                    BTOR:    rd_comb = op_a | op_b;
                    BTAND:   rd_comb = op_a & op_b;
                    default: rd_comb = '0;
                endcase
            end
            ALUAS:   rd_comb = (sub == 2'b01) ? sum : diff;
            ALUSH:   rd_comb = shift_res;
            default: rd_comb = {{(XLEN-1){1'b0}}, flag};
        endcase
    end

    // Writeback register: capture only on valid, valid itself always tracks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q    <= '0;
            flag_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                rd_q   <= rd_comb;
                flag_q <= flag;
            end
        end
    end

endmodule

// File: tb/tb_integer_unit.sv
// Directed bench for integer_unit: combinational ALU/flag vectors, then the
// registered path with hold and asynchronous reset.
module tb_integer_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        alu_imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        flag_inv;
    logic [31:0] rd_comb;
    logic        flag;
    logic [31:0] rd_q;
    logic        flag_q;
    logic        valid_q;

    int n_checks = 0;
    int n_fail   = 0;

    integer_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .alu_imm  (alu_imm),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .alu_op   (alu_op),
        .flag_inv (flag_inv),
        .rd_comb  (rd_comb),
        .flag     (flag),
        .rd_q     (rd_q),
        .flag_q   (flag_q),
        .valid_q  (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic use_imm,
                           input logic [3:0] op, input logic inv);
        rs1      = a;
        alu_imm  = use_imm;
        if (use_imm) begin
            imm = b;
            rs2 = 32'hDEAD_BEEF;
        end else begin
            rs2 = b;
            imm = 32'h1234_5678;
        end
        alu_op   = op;
        flag_inv = inv;
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; alu_imm = 1'b0;
        rs1 = '0; rs2 = '0; imm = '0; alu_op = '0; flag_inv = 1'b0;
        #2;
        check("reset rd_q",    rd_q,            32'h0);
        check("reset flag_q",  {31'b0, flag_q}, 32'h0);
        check("reset valid_q", {31'b0, valid_q},32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Add/sub
        set_ops(32'h7FFF_FFFF, 32'h1, 1'b1, 4'b0101, 1'b0);
        check("add wrap", rd_comb, 32'h8000_0000);
        check("add flag", {31'b0, flag}, 32'h0);
        set_ops(32'h7FFF_FFFF, 32'h1, 1'b0, 4'b0100, 1'b0);
        check("sub", rd_comb, 32'h7FFF_FFFE);

        // Bitwise
        set_ops(32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 4'b0001, 1'b0);
        check("xor", rd_comb, 32'hFF00_FF00);
        set_ops(32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 4'b0010, 1'b0);
        check("or", rd_comb, 32'hFFF0_FFF0);
        set_ops(32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 4'b0011, 1'b0);
        check("and", rd_comb, 32'h00F0_00F0);
        set_ops(32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 4'b0000, 1'b0);
        check("nop", rd_comb, 32'h0);

        // Shifts (upper bits of B ignored)
        set_ops(32'h8000_0001, 32'h21, 1'b0, 4'b1000, 1'b0);
        check("sll", rd_comb, 32'h0000_0002);
        set_ops(32'h8000_0001, 32'h21, 1'b0, 4'b1010, 1'b0);
        check("srl", rd_comb, 32'h4000_0000);
        set_ops(32'h8000_0001, 32'h21, 1'b1, 4'b1011, 1'b0);
        check("sra", rd_comb, 32'hC000_0000);
        set_ops(32'h8000_0001, 32'h21, 1'b0, 4'b1001, 1'b0);
        check("shift undef", rd_comb, 32'h0);
        set_ops(32'h8765_4321, 32'h0, 1'b0, 4'b1011, 1'b0);
        check("sra by 0", rd_comb, 32'h8765_4321);
        set_ops(32'h8765_4321, 32'hFFFF_FFE0, 1'b0, 4'b1000, 1'b0);
        check("sll by 0 hi bits", rd_comb, 32'h8765_4321);
        set_ops(32'h8000_0000, 32'd31, 1'b1, 4'b1011, 1'b0);
        check("sra 31", rd_comb, 32'hFFFF_FFFF);
        set_ops(32'h8000_0000, 32'd31, 1'b1, 4'b1010, 1'b0);
        check("srl 31", rd_comb, 32'h0000_0001);

        // Compare
        set_ops(32'hFFFF_FFFF, 32'h1, 1'b0, 4'b1100, 1'b0);
        check("slt rd", rd_comb, 32'h1);
        check("slt flag", {31'b0, flag}, 32'h1);
        set_ops(32'hFFFF_FFFF, 32'h1, 1'b0, 4'b1110, 1'b0);
        check("sltu rd", rd_comb, 32'h0);
        check("sltu flag", {31'b0, flag}, 32'h0);
        set_ops(32'hFFFF_FFFF, 32'h1, 1'b0, 4'b1100, 1'b1);
        check("slt inv flag", {31'b0, flag}, 32'h0);
        set_ops(32'h5, 32'h5, 1'b1, 4'b1111, 1'b0);
        check("seq flag", {31'b0, flag}, 32'h1);
        check("seq rd", rd_comb, 32'h1);
        set_ops(32'h8000_0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        check("blt min vs 0", {31'b0, flag}, 32'h1);
        set_ops(32'h8000_0000, 32'h0, 1'b0, 4'b0010, 1'b0);
        check("bltu min vs 0", {31'b0, flag}, 32'h0);
        set_ops(32'h8000_0000, 32'h0, 1'b0, 4'b0010, 1'b1);
        check("bgeu min vs 0", {31'b0, flag}, 32'h1);
        set_ops(32'h3, 32'h3, 1'b0, 4'b0011, 1'b0);
        check("beq taken", {31'b0, flag}, 32'h1);
        set_ops(32'h3, 32'h3, 1'b0, 4'b0011, 1'b1);
        check("bne not taken", {31'b0, flag}, 32'h0);
        set_ops(32'h3, 32'h3, 1'b0, 4'b0101, 1'b1);
        check("afadd inv", {31'b0, flag}, 32'h1);

        // Registered path: nothing captured while in_valid is low
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("idle rd_q", rd_q, 32'h0);
        check("idle valid_q", {31'b0, valid_q}, 32'h0);

        @(negedge clk);
        in_valid = 1'b1;
        set_ops(32'd2, 32'd3, 1'b0, 4'b0101, 1'b0);
        @(posedge clk); #1;
        check("reg add rd_q", rd_q, 32'd5);
        check("reg add valid_q", {31'b0, valid_q}, 32'h1);
        check("reg add flag_q", {31'b0, flag_q}, 32'h0);

        @(negedge clk);
        in_valid = 1'b0;
        set_ops(32'hFFFF_FFFF, 32'h1, 1'b0, 4'b1100, 1'b0);
        @(posedge clk); #1;
        check("hold rd_q", rd_q, 32'd5);
        check("hold flag_q", {31'b0, flag_q}, 32'h0);
        check("hold valid_q", {31'b0, valid_q}, 32'h0);

        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("reg slt rd_q", rd_q, 32'h1);
        check("reg slt flag_q", {31'b0, flag_q}, 32'h1);

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        check("async rst rd_q", rd_q, 32'h0);
        check("async rst flag_q", {31'b0, flag_q}, 32'h0);
        check("async rst valid_q", {31'b0, valid_q}, 32'h0);
        check("async rst rd_comb", rd_comb, 32'h1);
        @(posedge clk); #1;
        check("held in rst rd_q", rd_q, 32'h0);
        check("held in rst valid_q", {31'b0, valid_q}, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        set_ops(32'h10, 32'h4, 1'b1, 4'b0100, 1'b0);
        @(posedge clk); #1;
        check("post rst rd_q", rd_q, 32'hC);
        check("post rst valid_q", {31'b0, valid_q}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
